// File: rtl/bp_tag_packet_scheduler.sv
// Runtime bsg_tag packet scheduler: emits the tag-master reset preamble, then
// round-robin arbitrates requesters and serializes their packets bit-per-cycle.
module bp_tag_packet_scheduler #(
    parameter int num_req_p           = 2,
    parameter int num_clients_p       = 3,
    parameter int max_payload_width_p = 10,
    parameter int init_cycles_p       = 32,
    parameter int gap_cycles_p        = 1,
    localparam int id_width_lp  = (num_clients_p > 1) ? $clog2(num_clients_p) : 1,
    localparam int len_width_lp = $clog2(max_payload_width_p + 1)
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic [num_req_p-1:0]                   req_v_i,
    input  logic [num_req_p*id_width_lp-1:0]       req_id_i,
    input  logic [num_req_p-1:0]                   req_data_not_reset_i,
    input  logic [num_req_p*len_width_lp-1:0]      req_len_i,
    input  logic [num_req_p*max_payload_width_p-1:0] req_payload_i,
    output logic [num_req_p-1:0]                   req_yumi_o,
    output logic                                   tag_data_o,
    output logic                                   init_done_o,
    output logic                                   busy_o,
    output logic                                   err_o
);

    localparam int m1_lp      = (init_cycles_p > len_width_lp) ? init_cycles_p : len_width_lp;
    localparam int m2_lp      = (m1_lp > max_payload_width_p) ? m1_lp : max_payload_width_p;
    localparam int cnt_max_lp = (m2_lp > gap_cycles_p) ? m2_lp : gap_cycles_p;
    localparam int cnt_w_lp   = $clog2(cnt_max_lp + 1);
    localparam int ptr_w_lp   = (num_req_p > 1) ? $clog2(num_req_p) : 1;

    typedef enum logic [3:0] {
        S_INIT_ONES, S_INIT_ZEROS, S_IDLE, S_START, S_LEN, S_DNR, S_ID, S_PAYLOAD, S_GAP
    } state_e;

    localparam state_e S_AFTER_PAY = (gap_cycles_p == 0) ? S_IDLE : S_GAP;

    state_e                         state_q, state_d;
    logic [cnt_w_lp-1:0]            cnt_q, cnt_d;
    logic [ptr_w_lp-1:0]            ptr_q, ptr_d;
    logic                           tag_q, tag_d;
    logic [id_width_lp-1:0]         id_q, id_d;
    logic [len_width_lp-1:0]        len_q, len_d;
    logic                           dnr_q, dnr_d;
    logic [max_payload_width_p-1:0] pay_q, pay_d;

    logic [id_width_lp-1:0]         id_arr  [num_req_p];
    logic [len_width_lp-1:0]        len_arr [num_req_p];
    logic [max_payload_width_p-1:0] pay_arr [num_req_p];

    for (genvar r = 0; r < num_req_p; r++) begin : g_unpack
        assign id_arr[r]  = req_id_i[r*id_width_lp +: id_width_lp];
        assign len_arr[r] = req_len_i[r*len_width_lp +: len_width_lp];
        assign pay_arr[r] = req_payload_i[r*max_payload_width_p +: max_payload_width_p];
    end

    // First valid requester at or after the pointer, wrapping.
    logic                gnt_found;
    logic [ptr_w_lp-1:0] gnt_idx, cand;
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < num_req_p; i++) begin
            cand = ptr_w_lp'((int'(ptr_q) + i) % num_req_p);
            if (!gnt_found && req_v_i[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    logic grant, illegal;
    assign grant   = (state_q == S_IDLE) && gnt_found;
    assign illegal = (int'(len_arr[gnt_idx]) > max_payload_width_p) ||
                     (int'(id_arr[gnt_idx]) >= num_clients_p);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        len_d      = len_q;
        dnr_d      = dnr_q;
        pay_d      = pay_q;
        req_yumi_o = '0;
        err_o      = 1'b0;
        case (state_q)
            S_INIT_ONES: begin
                if (cnt_q == cnt_w_lp'(init_cycles_p)) begin
                    state_d = S_INIT_ZEROS;
                    cnt_d   = cnt_w_lp'(1);
                end else begin
                    cnt_d = cnt_q + cnt_w_lp'(1);
                end
            end
            S_INIT_ZEROS: begin
                if (cnt_q == cnt_w_lp'(init_cycles_p)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + cnt_w_lp'(1);
                end
            end
            S_IDLE: begin
                if (grant) begin
                    req_yumi_o = num_req_p'(1) << gnt_idx;
                    ptr_d      = (int'(gnt_idx) == num_req_p - 1) ? '0 : gnt_idx + ptr_w_lp'(1);
                    if (illegal) begin
                        err_o = 1'b1;
                    end else begin
                        state_d = S_START;
                        cnt_d   = '0;
                        id_d    = id_arr[gnt_idx];
                        len_d   = len_arr[gnt_idx];
                        dnr_d   = req_data_not_reset_i[gnt_idx];
                        pay_d   = pay_arr[gnt_idx];
                    end
                end
            end
            S_START: state_d = S_LEN;
            S_LEN: begin
                if (cnt_q == cnt_w_lp'(len_width_lp - 1)) begin
                    state_d = S_DNR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + cnt_w_lp'(1);
                end
            end
            S_DNR: state_d = S_ID;
            S_ID: begin
                if (cnt_q == cnt_w_lp'(id_width_lp - 1)) begin
                    state_d = (len_q != '0) ? S_PAYLOAD : S_AFTER_PAY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + cnt_w_lp'(1);
                end
            end
            S_PAYLOAD: begin
                if (cnt_q == cnt_w_lp'(len_q) - cnt_w_lp'(1)) begin
                    state_d = S_AFTER_PAY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + cnt_w_lp'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == cnt_w_lp'(gap_cycles_p - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + cnt_w_lp'(1);
                end
            end
            default: state_d = S_INIT_ONES;
        endcase
    end

    // The output bit is registered from the next state so it lines up with the state.
    always_comb begin
        case (state_d)
            S_INIT_ONES, S_START: tag_d = 1'b1;
            S_LEN:     tag_d = |(len_d & (len_width_lp'(1) << cnt_d));
            S_DNR:     tag_d = dnr_d;
            S_ID:      tag_d = |(id_d & (id_width_lp'(1) << cnt_d));
            S_PAYLOAD: tag_d = |(pay_d & (max_payload_width_p'(1) << cnt_d));
            default:   tag_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_INIT_ONES;
            cnt_q   <= '0;
            ptr_q   <= '0;
            tag_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            tag_q   <= tag_d;
        end
    end

    always_ff @(posedge clk_i) begin
        id_q  <= id_d;
        len_q <= len_d;
        dnr_q <= dnr_d;
        pay_q <= pay_d;
    end

    assign tag_data_o  = tag_q;
    assign init_done_o = !(state_q inside {S_INIT_ONES, S_INIT_ZEROS});
    assign busy_o      = !(state_q inside {S_INIT_ONES, S_INIT_ZEROS, S_IDLE});

endmodule

// File: tb/tb_bp_tag_packet_scheduler.sv
// Self-checking bench for bp_tag_packet_scheduler: queue-of-bits reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_bp_tag_packet_scheduler;

    localparam int N = 2, NCLI = 3, MAXP = 10, INIT = 32, GAP = 1, IDW = 2, LENW = 4;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [N-1:0]        req_v = '0;
    logic [N*IDW-1:0]    req_id = '0;
    logic [N-1:0]        req_dnr = '0;
    logic [N*LENW-1:0]   req_len = '0;
    logic [N*MAXP-1:0]   req_pay = '0;
    logic [N-1:0]        yumi;
    logic                tag, init_done, busy, err;

    bp_tag_packet_scheduler #(
        .num_req_p(N), .num_clients_p(NCLI), .max_payload_width_p(MAXP),
        .init_cycles_p(INIT), .gap_cycles_p(GAP)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .req_v_i(req_v), .req_id_i(req_id),
        .req_data_not_reset_i(req_dnr), .req_len_i(req_len), .req_payload_i(req_pay),
        .req_yumi_o(yumi), .tag_data_o(tag), .init_done_o(init_done), .busy_o(busy),
        .err_o(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of (tag, busy, init_done) per future cycle.
    typedef struct packed { logic tag; logic busy; logic init; } ent_t;
    ent_t q[$];
    int   mptr, cyc;

    function automatic ent_t mk(input logic t, input logic b, input logic i);
        ent_t e;
        e.tag = t; e.busy = b; e.init = i;
        return e;
    endfunction

    always @(negedge clk) begin : compare
        ent_t          e;
        logic [N-1:0]  ey;
        logic          ee;
        int            r;
        logic [IDW-1:0]  lid;
        logic [LENW-1:0] llen;
        logic [MAXP-1:0] lpay;
        if (!reset_n) begin
            chk("rst_tag", tag, 0);
            chk("rst_busy", busy, 0);
            chk("rst_init", init_done, 0);
            chk("rst_yumi", yumi, 0);
            chk("rst_err", err, 0);
            q.delete();
            q.push_back(mk(0, 0, 0));
            for (int k = 0; k < INIT; k++) q.push_back(mk(1, 0, 0));
            for (int k = 0; k < INIT; k++) q.push_back(mk(0, 0, 0));
            mptr = 0;
            cyc  = 0;
        end else begin
            ey = '0;
            ee = 1'b0;
            if (q.size() != 0) begin
                e = q.pop_front();
            end else begin
                e = mk(0, 0, 1);
                for (int k = 0; k < N; k++) begin
                    r = (mptr + k) % N;
                    if (ey == '0 && req_v[r]) begin
                        ey[r] = 1'b1;
                        mptr  = (r + 1) % N;
                        lid   = req_id[r*IDW +: IDW];
                        llen  = req_len[r*LENW +: LENW];
                        lpay  = req_pay[r*MAXP +: MAXP];
                        if (int'(llen) > MAXP || int'(lid) >= NCLI) begin
                            ee = 1'b1;
                        end else begin
                            q.push_back(mk(1, 1, 1));
                            for (int b = 0; b < LENW; b++) q.push_back(mk(llen[b], 1, 1));
                            q.push_back(mk(req_dnr[r], 1, 1));
                            for (int b = 0; b < IDW; b++) q.push_back(mk(lid[b], 1, 1));
                            for (int b = 0; b < int'(llen); b++) q.push_back(mk(lpay[b], 1, 1));
                            for (int b = 0; b < GAP; b++) q.push_back(mk(0, 1, 1));
                        end
                    end
                end
            end
            chk("m_tag", tag, e.tag);
            chk("m_busy", busy, e.busy);
            chk("m_init", init_done, e.init);
            chk("m_yumi", yumi, ey);
            chk("m_err", err, ee);
            if (cyc == 1)  chk("lit_pre_first_one", tag, 1);
            if (cyc == 32) chk("lit_pre_last_one", tag, 1);
            if (cyc == 33) chk("lit_pre_first_zero", tag, 0);
            if (cyc == 64) chk("lit_init_not_yet", init_done, 0);
            if (cyc == 65) chk("lit_init_rise", init_done, 1);
            cyc++;
        end
    end

    task automatic set_req(input int r, input logic [IDW-1:0] id, input logic dnr,
                           input logic [LENW-1:0] len, input logic [MAXP-1:0] pay);
        req_id[r*IDW +: IDW]    = id;
        req_dnr[r]              = dnr;
        req_len[r*LENW +: LENW] = len;
        req_pay[r*MAXP +: MAXP] = pay;
    endtask

    task automatic rand_legal(input int r);
        set_req(r, IDW'($urandom_range(0, NCLI - 1)), 1'($urandom), LENW'($urandom_range(0, MAXP)),
                MAXP'($urandom));
    endtask

    task automatic wait_yumi(input int r, output bit found);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (yumi[r]) begin
                found = 1'b1;
                return;
            end
        end
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic collect(input int n, output logic [31:0] bits, output int bc);
        bits = '0;
        bc   = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bits = {bits[30:0], tag};
            bc += int'(busy);
        end
    endtask

    task automatic illegal_pair(input string tagname, input logic [IDW-1:0] id1, input logic [LENW-1:0] len1);
        bit found;
        drive_edge();
        set_req(0, 0, 1, 2, 10'b11);
        set_req(1, id1, 1, len1, '0);
        req_v = 2'b11;
        wait_yumi(1, found);
        chk({tagname, "_seen"}, found, 1);
        chk({tagname, "_err"}, err, 1);
        chk({tagname, "_tag"}, tag, 0);
        chk({tagname, "_yumi"}, yumi, 2'b10);
        drive_edge();
        req_v[1] = 1'b0;
        @(negedge clk);
        chk({tagname, "_next_grant"}, yumi, 2'b01);
        chk({tagname, "_err_next"}, err, 0);
        drive_edge();
        req_v[0] = 1'b0;
        repeat (14) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit          found;
        int          gcyc, bc, grants, prev, g, c0, c1;
        logic [31:0] bits;
        logic [N-1:0] y;

        // Request held from reset: must not be accepted before the preamble ends.
        set_req(0, 2'd1, 1'b1, 4'd3, 10'b101);
        req_v[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        found = 1'b0;
        gcyc  = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (yumi[0]) begin
                found = 1'b1;
                gcyc  = i;
                break;
            end
        end
        chk("B_yumi_seen", found, 1);
        chk("B_grant_cycle", gcyc, 65);
        chk("B_yumi_onehot", yumi, 2'b01);
        drive_edge();
        req_v[0] = 1'b0;
        rand_legal(0);
        collect(12, bits, bc);
        chk("B_seq", bits, 32'b111001101010);
        chk("B_busy_cycles", bc, 12);
        @(negedge clk);
        chk("B_busy_after", busy, 0);

        illegal_pair("D_len11", 2'd1, 4'd11);
        illegal_pair("D_id3", 2'd3, 4'd2);

        drive_edge();
        set_req(1, 2'd2, 1'b0, 4'd0, 10'h3ff);
        req_v[1] = 1'b1;
        wait_yumi(1, found);
        chk("C_seen", found, 1);
        chk("C_err", err, 0);
        drive_edge();
        req_v[1] = 1'b0;
        collect(9, bits, bc);
        chk("C_seq", bits, 32'b100000010);
        chk("C_busy_cycles", bc, 9);

        // Both requesters continuously valid: grants must alternate.
        repeat (3) @(posedge clk);
        #1;
        rand_legal(0);
        rand_legal(1);
        req_v  = 2'b11;
        grants = 0; prev = -1; g = 0; c0 = 0; c1 = 0;
        for (int i = 0; i < 600 && grants < 8; i++) begin
            @(negedge clk);
            y = yumi;
            if (y != '0) begin
                g = y[1] ? 1 : 0;
                if (prev < 0) chk("E_first_grant", g, 0);
                else          chk("E_alternate", g, 1 - prev);
                prev = g;
                grants++;
                if (g == 0) c0++; else c1++;
            end
            drive_edge();
            if (y != '0) begin
                if (grants < 8) rand_legal(g);
                else            req_v[g] = 1'b0;
            end
        end
        chk("E_grants", grants, 8);
        chk("E_cnt0", c0, 4);
        chk("E_cnt1", c1, 4);
        wait_yumi(1 - g, found);
        chk("E_drain", found, 1);
        drive_edge();
        req_v = '0;
        repeat (20) @(posedge clk);

        // Reset in the middle of the payload.
        #1;
        set_req(0, 2'd0, 1'b1, 4'd10, 10'($urandom));
        req_v[0] = 1'b1;
        wait_yumi(0, found);
        chk("F_seen", found, 1);
        drive_edge();
        req_v[0] = 1'b0;
        repeat (9) @(negedge clk);
        chk("F_busy_before", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("F_tag_async", tag, 0);
        chk("F_init_async", init_done, 0);
        chk("F_busy_async", busy, 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (75) @(posedge clk);
        @(negedge clk);
        chk("F_init_back", init_done, 1);
        chk("F_no_resend", busy, 0);

        // Random traffic, including illegal requests and field churn after yumi.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            y = yumi;
            drive_edge();
            for (int r = 0; r < N; r++) begin
                if (!req_v[r] || y[r]) begin
                    rand_legal(r);
                    if ($urandom_range(0, 2) != 0) begin
                        if ($urandom_range(0, 7) == 0) begin
                            if ($urandom_range(0, 1) == 0) req_len[r*LENW +: LENW] = LENW'($urandom_range(11, 15));
                            else                           req_id[r*IDW +: IDW] = 2'd3;
                        end
                        req_v[r] = 1'b1;
                    end else begin
                        req_v[r] = 1'b0;
                    end
                end
            end
        end
        for (int i = 0; i < 200 && req_v != '0; i++) begin
            @(negedge clk);
            y = yumi;
            drive_edge();
            req_v = req_v & ~y;
        end
        chk("G_drained", req_v, 0);
        repeat (30) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_tag_packet_scheduler.md
Name: bp_tag_packet_scheduler

Overview:
- Runtime bsg_tag packet scheduler for the BlackParrot platform.
- Shares the single serial bsg_tag data line between up to num_req_p requesters, e.g. host-link and DRAM-link reconfiguration agents.
- After reset it emits the tag-master reset preamble. It then round-robin arbitrates queued tag writes and serializes each one bit-per-cycle into the bsg_tag_master data input.

Parameters:
- num_req_p, 2, number of requesters.
- num_clients_p, 3, number of bsg_tag clients. id_width_lp = BSG_SAFE_CLOG2(num_clients_p).
- max_payload_width_p, 10, largest payload in bits. len_width_lp = BSG_WIDTH(max_payload_width_p).
- init_cycles_p, 32, length in cycles of each preamble phase (ones phase, then zeros phase).
- gap_cycles_p, 1, forced idle zero cycles after each packet.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous, active-low reset
- req_v_i  in  num_req_p  per-requester request valid
- req_id_i  in  num_req_p*id_width_lp  target client id, requester r in slice r
- req_data_not_reset_i  in  num_req_p  1 = data write, 0 = client reset packet
- req_len_i  in  num_req_p*len_width_lp  payload length in bits
- req_payload_i  in  num_req_p*max_payload_width_p  payload, LSB first
- req_yumi_o  out  num_req_p  one-hot accept pulse
- tag_data_o  out  1  serial bsg_tag data to bsg_tag_master data_i
- init_done_o  out  1  preamble finished, level
- busy_o  out  1  packet or gap in progress
- err_o  out  1  one-cycle pulse when a request is dropped

Behaviour:
- Reset is asynchronous, active-low; clk_i is the only clock.
- Reset values:
  - state = INIT_ONES, counter = 0, round-robin pointer = 0.
  - tag_data_o = 0 during reset; it is registered and follows the state from the first edge after deassertion.
  - init_done_o = 0, busy_o = 0, req_yumi_o = 0, err_o = 0.
- INIT_ONES: tag_data_o = 1 for init_cycles_p cycles, then INIT_ZEROS.
- INIT_ZEROS: tag_data_o = 0 for init_cycles_p cycles, then IDLE. init_done_o rises on entry to IDLE and stays high until reset.
- No req_yumi_o is issued before init_done_o.
- IDLE: tag_data_o = 0.
  - If any req_v_i is set, grant the first valid requester at or after the pointer (wrapping).
  - req_yumi_o[g] is combinational that cycle (valid-then-yumi); it must not depend on yumi.
  - The request fields are captured into registers and the pointer advances to g+1 mod num_req_p.
- Legality is checked at grant.
  - Illegal: len > max_payload_width_p, or id >= num_clients_p.
  - An illegal request is still yumi'd. err_o pulses the same cycle, nothing is serialized, and the state stays IDLE; a new grant is possible next cycle.
- A legal grant moves to START on the next cycle, with busy_o = 1 from that cycle.
- Serialization, registered output, one bit per cycle:
  - START: 1 bit, value 1.
  - LEN: len_width_lp bits, LSB first.
  - DNR: 1 bit, data_not_reset.
  - ID: id_width_lp bits, LSB first.
  - PAYLOAD: len bits, LSB first. Skipped when len = 0.
  - GAP: gap_cycles_p zeros, then IDLE and busy_o = 0. GAP is skipped when gap_cycles_p = 0.
- Packet length = 2 + len_width_lp + id_width_lp + len cycles, excluding GAP.
- Back-to-back packets: the earliest next grant is the first IDLE cycle after GAP. With gap_cycles_p = 0, the IDLE grant cycle itself supplies one 0 between packets.
- Requester inputs are ignored outside grant cycles. Changes to req_v_i or fields during serialization do not affect the current packet.
- A valid request that is not granted stays pending; the requester must hold it until yumi.
- Reset asserted mid-packet aborts the packet immediately, with tag_data_o = 0, and the preamble restarts.
- Counter width is sized for max(init_cycles_p, len_width_lp, max_payload_width_p, gap_cycles_p).

Test Plan:
- Reset release, no requests -> tag_data_o high for exactly 32 cycles, then low for 32 cycles; init_done_o rises on cycle 65; req_v_i held high before then gets no yumi.
- Requester 0: id=1, dnr=1, len=3, payload=3'b101 -> yumi[0] in one cycle, then the 11-bit sequence 1,1,1,0,0,1,1,0,1,0,1, then one 0 gap, busy_o high for 12 cycles.
- Both requesters valid continuously with pointer=0 -> grants alternate 0,1,0,1; each requester's yumi appears once per packet; no starvation over 8 packets.
- Requester 1: len=11 (and separately id=3) -> yumi[1] and err_o pulse in the same cycle; tag_data_o stays 0; a pending requester 0 request is granted the next cycle.
- len=0, dnr=0, id=2 -> 8-bit sequence 1,0,0,0,0,0,0,1 with no payload bits.
- reset_n_i pulsed low mid-PAYLOAD -> tag_data_o drops to 0 asynchronously; init_done_o returns to 0; the full preamble repeats; the aborted request is not re-sent unless the requester re-presents it.
